dac_spi_tx: RTL and testbench

- Output-side counterpart of the effects stage. Takes the processed sign-magnitude sample (sendVoltage, 11 bits) once per sample frame.
- Re-centres the sample around the DAC midscale offset and clamps it to an unsigned 10-bit code.
- Serialises a 16-bit command word to an MCP49x1-class 10-bit SPI DAC, then pulses LDAC so the output updates synchronously.
- Sits between the effects stage and the FPGA DAC pins. Started by the frame sequencer on a fixed counter value.

---
 rtl/dac_spi_tx_if.sv | 28 ++
 rtl/dac_spi_tx.sv | 175 +++++++++++++++++
 tb/tb_dac_spi_tx.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the effects stage and the DAC serialiser.
// master = effects stage / sequencer, slave = dac_spi_tx.
interface dac_spi_tx_if;
  logic        start;
  logic [10:0] send_voltage;
  logic [9:0]  offset;
  logic        busy;
  logic        done;
  logic [9:0]  last_code;

  modport master (
    output start,
    output send_voltage,
    output offset,
    input  busy,
    input  done,
    input  last_code
  );

  modport slave (
    input  start,
    input  send_voltage,
    input  offset,
    output busy,
    output done,
    output last_code
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Re-centres a sign-magnitude sample, clamps it to 10 bits and ships it
// to an MCP49x1-class SPI DAC, then strobes LDAC.
module dac_spi_tx #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] CONFIG  = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  dac_spi_tx_if.slave bus,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        ldac_n
);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX =
    DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LATCH
  } state_e;

  state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [14:0] rem_q, rem_d;
  logic [9:0]  code_q, code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        ldac_n_q, ldac_n_d;

  logic [9:0]  mag;
  logic [10:0] sum;
  logic [10:0] diff;
  logic [9:0]  code_in;
  logic [15:0] frame_w;
  logic        div_last;

  // Both operands are < 1024, so bit 10 flags overflow / borrow.
  always_comb begin
    mag  = bus.send_voltage[9:0];
    sum  = {1'b0, bus.offset} + {1'b0, mag};
    diff = {1'b0, bus.offset} - {1'b0, mag};
    if (bus.send_voltage[10]) begin
      code_in = diff[10] ? 10'd0 : diff[9:0];
    end else begin
      code_in = sum[10] ? 10'h3ff : sum[9:0];
    end
    frame_w = {CONFIG, code_in, 2'b00};
  end

  assign div_last = (div_q == DIV_MAX);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    rem_d    = rem_q;
    code_d   = code_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    ldac_n_d = ldac_n_q;

    if (state_q != IDLE) begin
      div_d = div_last ? '0 : div_q + DW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          div_d   = '0;
          rem_d   = frame_w[14:0];
          code_d  = code_in;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = frame_w[15];
        end
      end
      SETUP: begin
        if (div_last) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (div_last) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            // mosi only moves on the falling edge
            if (bit_q != 5'd15) begin
              mosi_d = rem_q[14];
              rem_d  = {rem_q[13:0], 1'b0};
            end
          end else if (bit_q == 5'd15) begin
            state_d = HOLD;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          state_d  = LATCH;
          ldac_n_d = 1'b0;
        end
      end
      LATCH: begin
        if (div_last) begin
          state_d  = IDLE;
          ldac_n_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      rem_q    <= '0;
      code_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      rem_q    <= rem_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.last_code = code_q;
  assign sclk          = sclk_q;
  assign mosi          = mosi_q;
  assign cs_n          = cs_n_q;
  assign ldac_n        = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a CLK_DIV=4 unit and a CLK_DIV=1 unit
// side by side, with an SPI pin monitor decoding each frame.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst_v;
  logic [1:0]  start_v;
  logic [10:0] sv_v [2];
  logic [9:0]  off_v [2];

  logic sclk0, mosi0, cs0, ldac0;
  logic sclk1, mosi1, cs1, ldac1;
  logic [1:0] sclk_v, mosi_v, cs_v, ldac_v;
  logic [1:0] busy_v, done_v;
  logic [9:0] lc_v [2];

  dac_spi_tx_if bus0 ();
  dac_spi_tx_if bus1 ();

  assign bus0.start        = start_v[0];
  assign bus0.send_voltage = sv_v[0];
  assign bus0.offset       = off_v[0];
  assign bus1.start        = start_v[1];
  assign bus1.send_voltage = sv_v[1];
  assign bus1.offset       = off_v[1];

  assign sclk_v = {sclk1, sclk0};
  assign mosi_v = {mosi1, mosi0};
  assign cs_v   = {cs1, cs0};
  assign ldac_v = {ldac1, ldac0};
  assign busy_v = {bus1.busy, bus0.busy};
  assign done_v = {bus1.done, bus0.done};
  assign lc_v[0] = bus0.last_code;
  assign lc_v[1] = bus1.last_code;

  dac_spi_tx #(.CLK_DIV(4)) u_dut4 (
    .clk    (clk),
    .reset  (rst_v[0]),
    .bus    (bus0.slave),
    .sclk   (sclk0),
    .mosi   (mosi0),
    .cs_n   (cs0),
    .ldac_n (ldac0)
  );

  dac_spi_tx #(.CLK_DIV(1)) u_dut1 (
    .clk    (clk),
    .reset  (rst_v[1]),
    .bus    (bus1.slave),
    .sclk   (sclk1),
    .mosi   (mosi1),
    .cs_n   (cs1),
    .ldac_n (ldac1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  function automatic int dv(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // SPI monitor: decode bits on sclk rises, guard protocol rules
  logic [1:0]  psclk = 2'b00;
  logic [1:0]  pcs   = 2'b11;
  logic [15:0] sh [2];
  int          rises [2];
  int          ldc [2];
  logic [15:0] cap_word [2];
  int          cap_rises [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_v[k]) begin
        psclk[k] <= 1'b0;
        pcs[k]   <= 1'b1;
        rises[k] <= 0;
      end else begin
        if (pcs[k] && !cs_v[k]) begin
          sh[k]    <= '0;
          rises[k] <= 0;
          ldc[k]   <= 0;
        end
        if (cs_v[k] != pcs[k])
          chk("cs_vs_sclk", {psclk[k], sclk_v[k]}, 0);
        if (!psclk[k] && sclk_v[k]) begin
          rises[k] <= rises[k] + 1;
          sh[k]    <= {sh[k][14:0], mosi_v[k]};
          chk("rise_cs_low", cs_v[k], 0);
        end
        if (!ldac_v[k]) begin
          ldc[k] <= ldc[k] + 1;
          chk("ldac_cs_high", cs_v[k], 1);
        end
        if (!pcs[k] && cs_v[k]) begin
          cap_word[k]  <= sh[k];
          cap_rises[k] <= rises[k];
        end
        psclk[k] <= sclk_v[k];
        pcs[k]   <= cs_v[k];
      end
    end
  end

  int t0_v [2];

  // Called at a negedge; pulses start for the next posedge.
  task automatic start_frame(
    input int          k,
    input logic [10:0] sv,
    input logic [9:0]  off,
    input logic [9:0]  ecode,
    input string       tag
  );
    sv_v[k]    = sv;
    off_v[k]   = off;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    t0_v[k]    = cyc;
    chk({tag, "_cs_fall"}, cs_v[k], 0);
    chk({tag, "_busy"}, busy_v[k], 1);
    chk({tag, "_code"}, lc_v[k], ecode);
    chk({tag, "_no_done"}, done_v[k], 0);
  endtask

  // Returns at the negedge where done is high.
  task automatic finish_frame(
    input int          k,
    input logic [15:0] eword,
    input string       tag
  );
    int  lim;
    bit  seen;
    lim  = 40 * dv(k) + 10;
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (done_v[k]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_cycles"}, cyc - t0_v[k], 35 * dv(k));
      chk({tag, "_word"}, cap_word[k], eword);
      chk({tag, "_rises"}, cap_rises[k], 16);
      chk({tag, "_ldac_len"}, ldc[k], dv(k));
      chk({tag, "_busy_clr"}, busy_v[k], 0);
    end
  endtask

  function automatic logic [9:0] ref_code(
    input logic [10:0] sv,
    input logic [9:0]  off
  );
    int v;
    if (sv[10]) v = int'(off) - int'(sv[9:0]);
    else        v = int'(off) + int'(sv[9:0]);
    if (v < 0)    v = 0;
    if (v > 1023) v = 1023;
    return v[9:0];
  endfunction

  localparam int NV = 7;
  logic [10:0] tv_sv [NV] = '{
    {1'b0, 10'h05a}, {1'b1, 10'h05a}, {1'b1, 10'h000},
    {1'b0, 10'h3ff}, {1'b1, 10'h3ff}, {1'b0, 10'h001},
    {1'b0, 10'h000}
  };
  logic [9:0] tv_off [NV] = '{
    10'h200, 10'h200, 10'h200,
    10'h200, 10'h200, 10'h3ff,
    10'h000
  };
  logic [9:0] tv_code [NV] = '{
    10'h25a, 10'h1a6, 10'h200,
    10'h3ff, 10'h000, 10'h3ff,
    10'h000
  };
  logic [15:0] tv_word [NV] = '{
    16'h3968, 16'h3698, 16'h3800,
    16'h3ffc, 16'h3000, 16'h3ffc,
    16'h3000
  };

  initial begin
    bit          hit;
    bit          dseen;
    logic [31:0] r;
    logic [10:0] rsv;
    logic [9:0]  roff;
    logic [9:0]  rcode;

    rst_v   = 2'b11;
    start_v = 2'b00;
    for (int k = 0; k < 2; k++) begin
      sv_v[k]  = '0;
      off_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_cs", cs0, 1);
    chk("rst_ldac", ldac0, 1);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_code", lc_v[0], 0);
    rst_v = 2'b00;
    @(negedge clk);

    // Directed conversion / clamp table
    for (int i = 0; i < NV; i++) begin
      start_frame(0, tv_sv[i], tv_off[i], tv_code[i],
                  $sformatf("vec%0d", i));
      finish_frame(0, tv_word[i], $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done_v[0], 0);
    end

    // start mid-frame is dropped
    start_frame(0, {1'b0, 10'h100}, 10'h080, 10'h180, "hs_a");
    repeat (48) @(negedge clk);
    sv_v[0]    = {1'b0, 10'h3ff};
    off_v[0]   = 10'h3ff;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("hs_a_keep_code", lc_v[0], 10'h180);
    chk("hs_a_keep_busy", busy_v[0], 1);
    finish_frame(0, 16'h3600, "hs_a");

    // start in the done cycle is accepted
    start_frame(0, {1'b1, 10'h010}, 10'h200, 10'h1f0, "hs_b");
    finish_frame(0, 16'h37c0, "hs_b");
    @(negedge clk);

    // reset during bit 7 abandons the frame
    start_frame(0, {1'b0, 10'h05a}, 10'h200, 10'h25a, "rst_mid");
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rises[0] == 9) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_reach_b7", hit, 1);
    #2 rst_v[0] = 1'b1;
    #1;
    chk("rst_mid_sclk", sclk0, 0);
    chk("rst_mid_cs", cs0, 1);
    chk("rst_mid_ldac", ldac0, 1);
    chk("rst_mid_busy", busy_v[0], 0);
    chk("rst_mid_code", lc_v[0], 0);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0;
    dseen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done_v[0] || !ldac0) dseen = 1'b1;
    end
    chk("rst_mid_no_done", dseen, 0);
    start_frame(0, {1'b1, 10'h05a}, 10'h200, 10'h1a6, "post_rst");
    finish_frame(0, 16'h3698, "post_rst");
    @(negedge clk);

    // CLK_DIV=1 unit, random back-to-back frames
    for (int i = 0; i < 200; i++) begin
      r     = $urandom;
      rsv   = r[10:0];
      roff  = r[25:16];
      rcode = ref_code(rsv, roff);
      start_frame(1, rsv, roff, rcode, $sformatf("rnd%0d", i));
      finish_frame(1, {4'b0011, rcode, 2'b00},
                   $sformatf("rnd%0d", i));
    end
    @(negedge clk);
    chk("rnd_idle_done", done_v[1], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
